// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the PE scheduler: FSM states, the fixed
// per-lane operation map and the width of the completed-job counter.
package pe_sched_pkg;

  localparam int JOBS_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Lane i of the PE array performs operation i % 4.
  typedef enum logic [1:0] {
    OP_INC = 2'd0,
    OP_DEC = 2'd1,
    OP_SHL = 2'd2,
    OP_SHR = 2'd3
  } lane_op_t;

  function automatic lane_op_t lane_op(input int lane);
    return lane_op_t'(lane % 4);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans the request vector starting at ptr and returns
// the first set requester as both a one-hot grant and an encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  assign any_req = |req;

  // Rotating priority search: first requester at or after ptr wins.
  always_comb begin
    logic found;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/pe_scheduler.sv
// PE scheduler: accepts one job at a time from NUM_REQ requesters by
// round-robin, drives its operand onto the chosen PE lane for two cycles,
// captures the lane's registered result and holds it until the consumer
// takes it.
// Optional feature: define PE_SCHED_STATS_EN to build the saturating
// completed-job counter behind jobs_done; otherwise jobs_done is tied to 0.
module pe_scheduler
  import pe_sched_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  ARRAY_SIZE = 4,
  parameter int  DATA_WIDTH = 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int LANE_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0][LANE_W-1:0]        req_lane,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] pe_data_in,
  input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] pe_data_out,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic [ID_W-1:0]                       rsp_id,
  output logic [JOBS_W-1:0]                     jobs_done
);

  state_t                  state, next_state;
  logic [ID_W-1:0]         ptr, next_ptr;
  logic [ID_W-1:0]         job_id;
  logic [LANE_W-1:0]       job_lane, lane_sel;
  logic [DATA_WIDTH-1:0]   job_data;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_idx;
  logic                    any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Out-of-range lane requests fall back to lane 0; pointer wraps after the last requester.
  assign lane_sel = (int'(req_lane[grant_idx]) >= ARRAY_SIZE) ? '0 : req_lane[grant_idx];
  assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and combinational outputs; reset forces handshake and lane drive low.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    pe_data_in = '0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready  = grant;
          next_state = EXEC;
        end
      end
      EXEC: begin
        pe_data_in[job_lane] = job_data;
        next_state           = CAPT;
      end
      CAPT: begin
        pe_data_in[job_lane] = job_data;
        next_state           = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (rst) begin
      req_ready  = '0;
      pe_data_in = '0;
      rsp_valid  = 1'b0;
    end
  end

  // Job latch on accept, result capture in CAPT; response registers hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      job_id   <= '0;
      job_lane <= '0;
      job_data <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            job_data <= req_data[grant_idx];
            job_lane <= lane_sel;
            job_id   <= grant_idx;
            ptr      <= next_ptr;
          end
        end
        CAPT: begin
          rsp_data <= pe_data_out[job_lane];
          rsp_id   <= job_id;
        end
        default: ;
      endcase
    end
  end

`ifdef PE_SCHED_STATS_EN
  logic [JOBS_W-1:0] jobs_cnt;

  // Saturating count of accepted responses.
  always_ff @(posedge clk) begin
    if (rst)
      jobs_cnt <= '0;
    else if (rsp_valid && rsp_ready && (jobs_cnt != {JOBS_W{1'b1}}))
      jobs_cnt <= jobs_cnt + JOBS_W'(1);
  end

  assign jobs_done = jobs_cnt;
`else
  assign jobs_done = '0;
`endif

endmodule

// File: tb/tb_pe_scheduler.sv
// Self-checking bench for pe_scheduler: a behavioural PE array feeds the DUT,
// and a spec-level model (rotating pointer, per-lane arithmetic, job count)
// predicts grants, responses and jobs_done for directed and random jobs.
module tb_pe_scheduler;
  import pe_sched_pkg::*;

`ifdef PE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [3:0]           req_valid = '0;
  logic [3:0]           req_ready;
  logic [3:0][7:0]      req_data = '0;
  logic [3:0][1:0]      req_lane = '0;
  logic [3:0][7:0]      pe_data_in;
  logic [3:0][7:0]      pe_data_out = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [7:0]           rsp_data;
  logic [1:0]           rsp_id;
  logic [15:0]          jobs_done;

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_m    = 0;
  int jobs_m   = 0;
  int cyc      = 0;

  pe_scheduler #(.NUM_REQ(4), .ARRAY_SIZE(4), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_lane    (req_lane),
    .pe_data_in  (pe_data_in),
    .pe_data_out (pe_data_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .jobs_done   (jobs_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane arithmetic of the PE array (8-bit, wrapping).
  function automatic logic [7:0] pe_ref(input int lane, input logic [7:0] d);
    case (lane_op(lane))
      OP_INC:  return d + 8'd1;
      OP_DEC:  return d - 8'd1;
      OP_SHL:  return {d[6:0], 1'b0};
      default: return d >> 1;
    endcase
  endfunction

  // Behavioural PE array: one registered result per lane.
  always @(posedge clk)
    for (int i = 0; i < 4; i++) pe_data_out[i] <= pe_ref(i, pe_data_in[i]);

  function automatic int exp_grant(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
    return -1;
  endfunction

  function automatic logic [15:0] exp_jobs();
    if (!STATS) return 16'd0;
    return (jobs_m > 65535) ? 16'hFFFF : 16'(jobs_m);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant; called just after a rising edge.
  task automatic wait_grant(output int g, output int t, output bit ok);
    ok = 1'b0; g = -1; t = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        t  = cyc;
        ok = 1'b1;
        n_checks++;
        if (!$onehot(req_ready)) $display("FAIL grant_onehot: got %b expected one-hot", req_ready);
        else n_pass++;
        return;
      end
      next_cycle();
    end
    n_checks++;
    $display("FAIL grant_timeout: got no req_ready expected a grant within 16 cycles");
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1; req_valid = '0;
    next_cycle();
    rst = 1'b0;
    ptr_m = 0; jobs_m = 0;
  endtask

  // Drives one job from the requesters in vld (data/lane preset by caller),
  // checks grant, lane drive, latency and response; hold>0 stalls rsp_ready.
  task automatic run_job(input logic [3:0] vld, input int hold, output int g, output logic [7:0] got);
    int t0, eg; bit ok;
    logic [3:0][7:0] exp_pe;
    logic [7:0] exp_d;
    logic [1:0] ln;
    got = '0;
    next_cycle();
    req_valid = vld; rsp_ready = (hold == 0);
    eg = exp_grant(vld);
    wait_grant(g, t0, ok);
    if (!ok) begin
      req_valid = '0; rsp_ready = 1'b1;
      repeat (8) next_cycle();
      return;
    end
    n_checks++;
    if (g !== eg) $display("FAIL grant_order: got %0d expected %0d", g, eg); else n_pass++;
    n_checks++;
    if (jobs_done !== exp_jobs()) $display("FAIL jobs_done: got %0d expected %0d", jobs_done, exp_jobs());
    else n_pass++;
    ln = req_lane[eg];
    exp_d = pe_ref(int'(ln), req_data[eg]);
    exp_pe = '0; exp_pe[ln] = req_data[eg];
    ptr_m = (eg + 1) % 4;

    next_cycle(); req_valid = '0; @(negedge clk);
    n_checks++;
    if ({rsp_valid, pe_data_in} !== {1'b0, exp_pe})
      $display("FAIL exec_drive: got v=%b pe=%h expected v=0 pe=%h", rsp_valid, pe_data_in, exp_pe);
    else n_pass++;
    next_cycle(); @(negedge clk);
    n_checks++;
    if ({rsp_valid, pe_data_in} !== {1'b0, exp_pe})
      $display("FAIL capt_drive: got v=%b pe=%h expected v=0 pe=%h", rsp_valid, pe_data_in, exp_pe);
    else n_pass++;
    next_cycle(); @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, exp_d, 2'(eg)})
      $display("FAIL response: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d", rsp_valid, rsp_data, rsp_id, exp_d, eg);
    else n_pass++;
    got = rsp_data;
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        next_cycle(); req_valid = '1; @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, exp_d, 2'(eg), 4'b0})
          $display("FAIL stall_hold: got v=%b d=%h id=%0d rdy=%b expected v=1 d=%h id=%0d rdy=0000",
                   rsp_valid, rsp_data, rsp_id, req_ready, exp_d, eg);
        else n_pass++;
      end
      next_cycle(); req_valid = '0; rsp_ready = 1'b1; @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_data} !== {1'b1, exp_d})
        $display("FAIL stall_release: got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_data, exp_d);
      else n_pass++;
      jobs_m++;
      next_cycle(); @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL stall_done: got v=%b expected v=0", rsp_valid); else n_pass++;
    end else begin
      jobs_m++;
    end
  endtask

  task automatic test_reset();
    req_valid = '1; req_data = '1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({req_ready, pe_data_in, rsp_valid, rsp_data, rsp_id, jobs_done} !== '0)
      $display("FAIL reset_outputs: got rdy=%b pe=%h v=%b d=%h id=%0d jd=%0d expected all 0",
               req_ready, pe_data_in, rsp_valid, rsp_data, rsp_id, jobs_done);
    else n_pass++;
    next_cycle(); rst = 1'b0; req_valid = '0; @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, pe_data_in} !== '0)
      $display("FAIL idle_hold: got rdy=%b v=%b pe=%h expected all 0", req_ready, rsp_valid, pe_data_in);
    else n_pass++;
    ptr_m = 0; jobs_m = 0;
  endtask

  task automatic test_single();
    int g; logic [7:0] got;
    req_data[0] = 8'h41; req_lane[0] = 2'd0;
    run_job(4'b0001, 0, g, got);
    n_checks++;
    if ({g[1:0], got} !== {2'd0, 8'h42}) $display("FAIL single_job: got id=%0d d=%h expected id=0 d=42", g, got);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] din [4]  = '{8'hFF, 8'h00, 8'h81, 8'h01};
    logic [7:0] dexp [4] = '{8'h00, 8'hFF, 8'h02, 8'h00};
    int g; logic [7:0] got;
    for (int k = 0; k < 4; k++) begin
      int r;
      r = $urandom_range(0, 3);
      req_data[r] = din[k]; req_lane[r] = 2'(k);
      run_job(4'b0001 << r, 0, g, got);
      n_checks++;
      if (got !== dexp[k]) $display("FAIL wrap_lane%0d: got %h expected %h", k, got, dexp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int g; logic [7:0] got;
    req_data[1] = 8'($urandom); req_lane[1] = 2'($urandom);
    run_job(4'b0010, 10, g, got);
  endtask

  task automatic test_round_robin();
    int g, t, t_prev, eg; bit ok;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_data[i] = 8'($urandom); req_lane[i] = 2'($urandom);
    end
    next_cycle(); req_valid = '1; rsp_ready = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, t, ok);
      if (!ok) break;
      eg = exp_grant(4'b1111);
      n_checks++;
      if (g !== eg || g !== (k % 4)) $display("FAIL rr_order: got %0d expected %0d", g, k % 4); else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (t - t_prev !== 4) $display("FAIL rr_spacing: got %0d expected 4", t - t_prev); else n_pass++;
      end
      t_prev = t;
      ptr_m = (eg + 1) % 4;
      exp_d = pe_ref(int'(req_lane[eg]), req_data[eg]);
      repeat (3) next_cycle();
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, exp_d, 2'(eg)})
        $display("FAIL rr_response: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d", rsp_valid, rsp_data, rsp_id, exp_d, eg);
      else n_pass++;
      jobs_m++;
      next_cycle();
      if (k == 4) req_valid = '0;
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int g, t; bit ok;
    next_cycle(); req_valid = 4'b0100; rsp_ready = 1'b1;
    wait_grant(g, t, ok);
    n_checks++;
    if (g !== 2) $display("FAIL mid_grant: got %0d expected 2", g); else n_pass++;
    next_cycle(); req_valid = '0;
    next_cycle(); rst = 1'b1; req_valid = '1; @(negedge clk);
    n_checks++;
    if ({req_ready, pe_data_in} !== '0)
      $display("FAIL rst_capt_outputs: got rdy=%b pe=%h expected all 0", req_ready, pe_data_in);
    else n_pass++;
    next_cycle(); rst = 1'b0; req_valid = '0; @(negedge clk);
    ptr_m = 0; jobs_m = 0;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_id, jobs_done, pe_data_in, req_ready} !== '0)
      $display("FAIL post_rst_outputs: got v=%b d=%h id=%0d jd=%0d pe=%h rdy=%b expected all 0",
               rsp_valid, rsp_data, rsp_id, jobs_done, pe_data_in, req_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL discarded_job: got v=%b expected v=0", rsp_valid); else n_pass++;
    end
    next_cycle(); req_valid = '1;
    wait_grant(g, t, ok);
    n_checks++;
    if (g !== 0 || g !== exp_grant(4'b1111)) $display("FAIL post_rst_grant: got %0d expected 0", g); else n_pass++;
    ptr_m = 1;
    next_cycle(); req_valid = '0;
    next_cycle(); next_cycle(); @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_id} !== {1'b1, 2'd0})
      $display("FAIL post_rst_rsp: got v=%b id=%0d expected v=1 id=0", rsp_valid, rsp_id);
    else n_pass++;
    jobs_m++;
  endtask

  task automatic test_random();
    int g; logic [7:0] got;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] v;
      v = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        req_data[i] = 8'($urandom); req_lane[i] = 2'($urandom);
      end
      run_job(v, ($urandom_range(0, 3) == 0) ? 2 : 0, g, got);
    end
  endtask

  task automatic test_stats();
    int g; logic [7:0] got;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_data[k % 4] = 8'($urandom); req_lane[k % 4] = 2'($urandom);
      run_job(4'b0001 << (k % 4), 0, g, got);
    end
    next_cycle(); @(negedge clk);
    n_checks++;
    if (jobs_done !== (STATS ? 16'd5 : 16'd0))
      $display("FAIL jobs_done_final: got %0d expected %0d", jobs_done, STATS ? 5 : 0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/pe_scheduler.md
PE_SCHEDULER -- requirements
Module: pe_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports.
REQ-002 The block SHALL have parameter ARRAY_SIZE, default 4, meaning the number of PE lanes driven; lane i performs operation i%4.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, meaning the operand and result width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, meaning a per-requester job request.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ, meaning a per-requester accept strobe.
REQ-008 The block SHALL have port req_data, input, NUM_REQ x DATA_WIDTH, meaning the per-requester operand.
REQ-009 The block SHALL have port req_lane, input, NUM_REQ x $clog2(ARRAY_SIZE), meaning the per-requester target lane.
REQ-010 The block SHALL have port pe_data_in, output, ARRAY_SIZE x DATA_WIDTH, meaning the operand to each PE lane.
REQ-011 The block SHALL have port pe_data_out, input, ARRAY_SIZE x DATA_WIDTH, meaning the registered result from each PE lane.
REQ-012 The block SHALL have port rsp_valid, output, 1, meaning a result is available.
REQ-013 The block SHALL have port rsp_ready, input, 1, meaning the consumer accepts the result.
REQ-014 The block SHALL have port rsp_data, output, DATA_WIDTH, meaning the result value.
REQ-015 The block SHALL have port rsp_id, output, $clog2(NUM_REQ), meaning the index of the originating requester.
REQ-016 The block SHALL have port jobs_done, output, 16, meaning the count of completed jobs (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, EXEC, CAPT and RESP, and only one job SHALL be in flight at a time.
REQ-018 In IDLE with any req_valid set, the round-robin grant g SHALL be chosen, req_ready[g] SHALL be asserted combinationally that cycle, req_data[g], req_lane[g] and g SHALL be latched, and the FSM SHALL go to EXEC.
REQ-019 req_ready SHALL be one-hot or zero, and SHALL be zero outside IDLE.
REQ-020 In IDLE with no req_valid set, the FSM SHALL stay in IDLE and all outputs SHALL hold.
REQ-021 In EXEC, pe_data_in[lane] SHALL equal the latched operand, all other lanes SHALL be driven 0, and the FSM SHALL go to CAPT.
REQ-022 In CAPT, the operand SHALL still be driven on pe_data_in[lane], pe_data_out[lane] SHALL be registered into rsp_data, and the FSM SHALL go to RESP.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_data and rsp_id SHALL be stable until the cycle in which rsp_ready=1, after which the FSM SHALL go to IDLE.
REQ-024 The latency from the req accept cycle to the first rsp_valid cycle SHALL be 3 cycles, and back-to-back jobs SHALL issue every 4 cycles with rsp_ready held at 1.
REQ-025 The round-robin pointer SHALL advance to g+1 mod NUM_REQ on accept, and the search SHALL begin at the pointer.
REQ-026 The pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-027 A requester that drops req_valid before grant SHALL lose no state and SHALL cause no error.
REQ-028 A req_lane value >= ARRAY_SIZE SHALL be replaced by lane 0 at latch time.
REQ-029 The scheduler SHALL NOT alter PE arithmetic: results wrap modulo 2^DATA_WIDTH, and a left shift drops the MSB.

Reset
REQ-030 With rst=1 at a clock edge, the FSM SHALL enter IDLE, the pointer SHALL be set to 0, rsp_valid, rsp_data and rsp_id SHALL be set to 0, and jobs_done SHALL be set to 0.
REQ-031 While rst=1, req_ready SHALL be 0 and pe_data_in SHALL be all 0.
REQ-032 Reset asserted in EXEC, CAPT or RESP SHALL discard the job with no response, and the first post-reset grant SHALL search from requester 0.

Configuration
REQ-033 With PE_SCHED_STATS_EN defined, jobs_done SHALL increment on each rsp_valid&&rsp_ready handshake and SHALL saturate at 16'hFFFF.
REQ-034 Without PE_SCHED_STATS_EN, the jobs_done port SHALL remain present, SHALL be tied to 0, and no counter logic SHALL be synthesised.

Structure
REQ-035 A shared package pe_sched_pkg SHALL hold the state enum (IDLE, EXEC, CAPT, RESP), the lane operation enum (OP_INC=0, OP_DEC=1, OP_SHL=2, OP_SHR=3) and the jobs_done width constant.
REQ-036 Round-robin selection SHALL be implemented in one sub-module rr_arbiter (inputs: request vector and pointer; outputs: one-hot grant and encoded index), parameterised by NUM_REQ.

Verification
REQ-037 The bench SHALL drive a single job (req 0, lane 0, data 8'h41) and SHALL require req_ready[0] in the same cycle, rsp_valid 3 cycles later, rsp_data=8'h42 and rsp_id=0.
REQ-038 The bench SHALL drive all four requesters continuously with rsp_ready=1 and SHALL require grants in the order 0,1,2,3,0 at a spacing of 4 cycles.
REQ-039 The bench SHALL drive wrap cases (lane 0 with 8'hFF, lane 1 with 8'h00, lane 2 with 8'h81) and SHALL require results 8'h00, 8'hFF and 8'h02 respectively.
REQ-040 The bench SHALL hold rsp_ready=0 for 10 cycles in RESP and SHALL require rsp_valid=1 with rsp_data and rsp_id unchanged, no new req_ready, and completion on the first rsp_ready=1 cycle.
REQ-041 The bench SHALL assert rst in CAPT and SHALL require no response, all outputs 0 on the next cycle, and the next grant to req 0 even if req 3 was due.
REQ-042 With PE_SCHED_STATS_EN defined, the bench SHALL run 5 jobs and SHALL require jobs_done=5; without the macro, it SHALL require jobs_done=0 throughout.
